// File: rtl/si5340_cfg_writer_if.sv
// Byte-source and bus-write handshake bundle for the Si5340 configuration writer.
// The writer uses the master modport; the byte source / bus-write side uses slave.
interface si5340_cfg_writer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] byte_i;
    logic                  byte_valid_i;
    logic                  byte_req_o;
    logic [7:0]            wr_addr_o;
    logic [7:0]            wr_data_o;
    logic                  wr_valid_o;
    logic                  wr_ready_i;
    logic [7:0]            page_o;
    logic                  done_o;

    modport master (
        input  byte_i,
        input  byte_valid_i,
        input  wr_ready_i,
        output byte_req_o,
        output wr_addr_o,
        output wr_data_o,
        output wr_valid_o,
        output page_o,
        output done_o
    );

    modport slave (
        output byte_i,
        output byte_valid_i,
        output wr_ready_i,
        input  byte_req_o,
        input  wr_addr_o,
        input  wr_data_o,
        input  wr_valid_o,
        input  page_o,
        input  done_o
    );
endinterface

// File: rtl/si5340_cfg_writer.sv
// Assembles 3-byte config words (data, addr_lo, addr_hi) and issues Si5340 register
// writes, inserting a page-select write whenever the target page is not yet programmed.
module si5340_cfg_writer #(
    parameter int         DATA_WIDTH  = 8,
    parameter int         MEM_WIDTH   = 24,
    parameter int         WORD_NUMBER = 326,
    parameter logic [7:0] PAGE_REG    = 8'h01
) (
    input logic                    clk_i,
    input logic                    rst_i,
    si5340_cfg_writer_if.master    bus
);

    localparam int BYTES = MEM_WIDTH / DATA_WIDTH;
    localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int WCW   = (WORD_NUMBER > 1) ? $clog2(WORD_NUMBER) : 1;
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(WORD_NUMBER - 1);

    typedef enum logic [2:0] {
        COLLECT,
        CHECK,
        PAGE_WR,
        REG_WR,
        NEXT
    } state_t;

    state_t         state_q, state_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [WCW-1:0] word_cnt_q, word_cnt_d;
    logic [7:0]     page_q, page_d;
    logic           page_valid_q, page_valid_d;
    logic           wr_valid_q, wr_valid_d;
    logic [7:0]     wr_addr_q, wr_addr_d;
    logic [7:0]     wr_data_q, wr_data_d;

    logic [DATA_WIDTH-1:0] slot_q [BYTES];
    logic [MEM_WIDTH-1:0]  word_w;
    logic [7:0]            cfg_data;
    logic [7:0]            addr_lo;
    logic [7:0]            addr_hi;
    logic                  byte_fire;
    logic                  wr_fire;

    assign byte_fire = (state_q == COLLECT) && bus.byte_valid_i;
    assign wr_fire   = wr_valid_q && bus.wr_ready_i;

    // One register per byte slot; the byte counter picks which slot captures.
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_slot
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                slot_q[gi] <= '0;
            end else if (byte_fire && (byte_cnt_q == BCW'(gi))) begin
                slot_q[gi] <= bus.byte_i;
            end
        end
        assign word_w[gi*DATA_WIDTH +: DATA_WIDTH] = slot_q[gi];
    end

    assign cfg_data = word_w[7:0];
    assign addr_lo  = word_w[15:8];
    assign addr_hi  = word_w[23:16];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= COLLECT;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            page_q       <= 8'h00;
            page_valid_q <= 1'b0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= 8'h00;
            wr_data_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            word_cnt_q   <= word_cnt_d;
            page_q       <= page_d;
            page_valid_q <= page_valid_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        word_cnt_d   = word_cnt_q;
        page_d       = page_q;
        page_valid_d = page_valid_q;
        wr_valid_d   = wr_valid_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        case (state_q)
            COLLECT: begin
                if (byte_fire) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        byte_cnt_d = '0;
                        state_d    = CHECK;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end

            CHECK: begin
                wr_valid_d = 1'b1;
                if (!page_valid_q || (addr_hi != page_q)) begin
                    state_d   = PAGE_WR;
                    wr_addr_d = PAGE_REG;
                    wr_data_d = addr_hi;
                end else begin
                    state_d   = REG_WR;
                    wr_addr_d = addr_lo;
                    wr_data_d = cfg_data;
                end
            end

            PAGE_WR: begin
                if (wr_fire) begin
                    page_d       = addr_hi;
                    page_valid_d = 1'b1;
                    wr_valid_d   = 1'b0;
                    state_d      = REG_WR;
                end
            end

            REG_WR: begin
                // Arriving from PAGE_WR, valid is low for one cycle so the two
                // writes are never accepted on consecutive edges.
                if (!wr_valid_q) begin
                    wr_valid_d = 1'b1;
                    wr_addr_d  = addr_lo;
                    wr_data_d  = cfg_data;
                end else if (wr_fire) begin
                    wr_valid_d = 1'b0;
                    state_d    = NEXT;
                    if (addr_lo == PAGE_REG) begin
                        page_d       = cfg_data;
                        page_valid_d = 1'b1;
                    end
                end
            end

            NEXT: begin
                state_d = COLLECT;
                if (word_cnt_q == LAST_WORD) begin
                    word_cnt_d   = '0;
                    page_valid_d = 1'b0;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    assign bus.byte_req_o = (state_q == COLLECT);
    assign bus.wr_valid_o = wr_valid_q;
    assign bus.wr_addr_o  = wr_addr_q;
    assign bus.wr_data_o  = wr_data_q;
    assign bus.page_o     = page_q;
    assign bus.done_o     = (state_q == NEXT) && (word_cnt_q == LAST_WORD);

endmodule

// File: doc/si5340_cfg_writer.md
SI5340_CFG_WRITER -- requirements
Module: si5340_cfg_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one config byte.
REQ-002 Parameter MEM_WIDTH, default 24: width of one config word (addr[23:8], data[7:0]).
REQ-003 Parameter WORD_NUMBER, default 326: words per full configuration image.
REQ-004 Parameter PAGE_REG, default 8'h01: device register address of the page select register.
REQ-005 clk_i  input  1  system clock; all logic on rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 byte_i  input  DATA_WIDTH  incoming config byte from byte source.
REQ-008 byte_valid_i  input  1  byte_i valid this cycle.
REQ-009 byte_req_o  output  1  ready for next byte; drives the source's ack input.
REQ-010 wr_addr_o  output  8  register address (low byte) for the bus-write master.
REQ-011 wr_data_o  output  8  register data for the bus-write master.
REQ-012 wr_valid_o  output  1  write request valid.
REQ-013 wr_ready_i  input  1  bus-write master accepts the write.
REQ-014 page_o  output  8  currently programmed page.
REQ-015 done_o  output  1  one-cycle pulse after final word of the image is written.

Function
REQ-016 Byte accepted only in cycles where byte_req_o=1 and byte_valid_i=1; byte_valid_i ignored otherwise.
REQ-017 Byte order per word: 1st accepted byte = data[7:0], 2nd = addr[7:0], 3rd = addr[15:8]; byte counter 0..MEM_WIDTH/DATA_WIDTH-1, wraps to 0 after 3rd byte.
REQ-018 States: COLLECT, CHECK, PAGE_WR, REG_WR, NEXT.
REQ-019 COLLECT: byte_req_o=1; store byte into slot selected by byte counter; after 3rd byte -> CHECK next cycle, byte_req_o=0 from that cycle.
REQ-020 CHECK (1 cycle): if page_valid=0 or addr[15:8]!=page_o -> PAGE_WR; else -> REG_WR.
REQ-021 PAGE_WR: wr_valid_o=1, wr_addr_o=PAGE_REG, wr_data_o=addr[15:8]; on wr_ready_i=1: page_o<=addr[15:8], page_valid<=1, -> REG_WR.
REQ-022 REG_WR: wr_valid_o=1, wr_addr_o=addr[7:0], wr_data_o=data; on wr_ready_i=1 -> NEXT.
REQ-023 wr_addr_o/wr_data_o held stable while wr_valid_o=1 and wr_ready_i=0; no limit on stall length.
REQ-024 wr_valid_o deasserts in cycle after acceptance; never two writes accepted back-to-back without a state change.
REQ-025 NEXT (1 cycle): word counter increments; at WORD_NUMBER-1 wraps to 0, done_o=1 for that cycle, page_valid<=0; -> COLLECT.
REQ-026 Word whose addr[15:8]==PAGE_REG's page and addr[7:0]==PAGE_REG is written as a normal REG_WR and also updates page_o<=data on acceptance.
REQ-027 Minimum latency, last byte accepted to wr_valid_o=1: 2 cycles (CHECK, then write state).
REQ-028 byte_req_o=0 in all states except COLLECT; bytes offered outside COLLECT are not consumed.
REQ-029 Word counter width $clog2(WORD_NUMBER); byte counter width $clog2(MEM_WIDTH/DATA_WIDTH).

Reset
REQ-030 rst_i=1 at a clock edge: state<=COLLECT, byte and word counters<=0, page_o<=8'h00, page_valid<=0, wr_valid_o<=0, wr_addr_o<=0, wr_data_o<=0, done_o<=0, byte_req_o=1 from first cycle after reset release.
REQ-031 Reset mid-word or mid-write discards partial word and pending write; no write issued for it after release.

Verification
REQ-032 Reset, bytes 8'h5A,8'h0B,8'h02 with wr_ready_i=1 -> writes (8'h01,8'h02) then (8'h0B,8'h5A); page_o=8'h02.
REQ-033 Next word 8'h11,8'h0C,8'h02 -> single write (8'h0C,8'h11), no page write.
REQ-034 Word on page 8'h05 after page 8'h02 -> page write (8'h01,8'h05) precedes register write.
REQ-035 wr_ready_i=0 for 10 cycles during REG_WR -> wr_valid_o, wr_addr_o, wr_data_o constant; byte_req_o=0 throughout.
REQ-036 WORD_NUMBER=2, two words streamed -> done_o one-cycle pulse after second REG_WR acceptance; third word forces page write again.
REQ-037 rst_i asserted after 2nd byte of a word -> no write issued; next 3 bytes treated as a fresh word with page write.
